// File: rtl/pipelined_cla_adder_if.sv
// Valid/ready streaming bundle for pipelined_cla_adder: operand beats in, result beats out.
interface pipelined_cla_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead block per stage,
// group carry registered between stages, one global advance for the whole pipe.
module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   pipelined_cla_adder_if.slave bus
);
   localparam int STAGES = WIDTH / GROUP;

   logic             w_advance;
   logic [WIDTH-1:0] w_bEff;
   logic             r_ovf;

   // Every carry is a flat sum of products of g/p/c0, so there is no ripple inside a group.
   function automatic logic [GROUP:0] lookahead(
      input logic [GROUP-1:0] g,
      input logic [GROUP-1:0] p,
      input logic             c0
   );
      logic [GROUP:0] c;
      logic           term;
      c    = '0;
      c[0] = c0;
      for (int i = 1; i <= GROUP; i++) begin
         term = c0;
         for (int j = 0; j < i; j++) term = term & p[j];
         c[i] = term;
         for (int j = 0; j < i; j++) begin
            term = g[j];
            for (int m = j + 1; m < i; m++) term = term & p[m];
            c[i] = c[i] | term;
         end
      end
      return c;
   endfunction

   assign w_bEff    = bus.sub ? ~bus.b : bus.b;
   assign w_advance = !gStage[STAGES-1].r_valid || bus.out_ready;

   genvar k;
   for (k = 0; k < STAGES; k++) begin : gStage
      localparam int FWD = WIDTH - (k + 1) * GROUP;

      logic [GROUP-1:0]       w_grpA;
      logic [GROUP-1:0]       w_grpB;
      logic                   w_carryIn;
      logic                   w_validIn;
      logic [GROUP-1:0]       w_g;
      logic [GROUP-1:0]       w_p;
      logic [GROUP:0]         w_c;
      logic [GROUP-1:0]       w_grpSum;
      logic [(k+1)*GROUP-1:0] w_sumNext;

      logic                   r_valid;
      logic                   r_carry;
      logic [(k+1)*GROUP-1:0] r_sum;

      if (k == 0) begin : gSrc
         assign w_grpA    = bus.a[GROUP-1:0];
         assign w_grpB    = w_bEff[GROUP-1:0];
         assign w_carryIn = bus.sub | bus.cin;
         assign w_validIn = bus.in_valid;
         assign w_sumNext = w_grpSum;
      end else begin : gSrc
         assign w_grpA    = gStage[k-1].gFwd.r_opA[GROUP-1:0];
         assign w_grpB    = gStage[k-1].gFwd.r_opB[GROUP-1:0];
         assign w_carryIn = gStage[k-1].r_carry;
         assign w_validIn = gStage[k-1].r_valid;
         assign w_sumNext = {w_grpSum, gStage[k-1].r_sum};
      end

      assign w_g      = w_grpA & w_grpB;
      assign w_p      = w_grpA ^ w_grpB;
      assign w_c      = lookahead(w_g, w_p, w_carryIn);
      assign w_grpSum = w_p ^ w_c[GROUP-1:0];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_valid <= 1'b0;
            r_carry <= 1'b0;
            r_sum   <= '0;
         end else if (w_advance) begin
            r_valid <= w_validIn;
            r_carry <= w_c[GROUP];
            r_sum   <= w_sumNext;
         end
      end

      // Operand bits of groups not yet resolved ride along unmodified with the beat.
      if (FWD > 0) begin : gFwd
         logic [FWD-1:0] w_fwdA;
         logic [FWD-1:0] w_fwdB;
         logic [FWD-1:0] r_opA;
         logic [FWD-1:0] r_opB;

         if (k == 0) begin : gTap
            assign w_fwdA = bus.a[WIDTH-1:GROUP];
            assign w_fwdB = w_bEff[WIDTH-1:GROUP];
         end else begin : gTap
            assign w_fwdA = gStage[k-1].gFwd.r_opA[FWD+GROUP-1:GROUP];
            assign w_fwdB = gStage[k-1].gFwd.r_opB[FWD+GROUP-1:GROUP];
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_opA <= '0;
               r_opB <= '0;
            end else if (w_advance) begin
               r_opA <= w_fwdA;
               r_opB <= w_fwdB;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_advance) begin
         r_ovf <= gStage[STAGES-1].w_c[GROUP] ^ gStage[STAGES-1].w_c[GROUP-1];
      end
   end

   assign bus.in_ready  = w_advance;
   assign bus.out_valid = gStage[STAGES-1].r_valid;
   assign bus.sum       = gStage[STAGES-1].r_sum;
   assign bus.cout      = gStage[STAGES-1].r_carry;
   assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder at 16/4, 8/4 and 32/8, checked against an
// arithmetic reference model.
module tb_pipelined_cla_adder;
   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   nChecks = 0;
   int   nErrors = 0;
   exp_t q16[$];
   exp_t q8[$];
   exp_t q32[$];

   pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
   pipelined_cla_adder_if #(.WIDTH(8))  bus8 ();
   pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();

   pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   pipelined_cla_adder #(.WIDTH(8),  .GROUP(4)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   pipelined_cla_adder #(.WIDTH(32), .GROUP(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   // Free-running clock shared by all three instances.
   always #5 clk = ~clk;

   // Reference: plain integer add or subtract, carry/borrow and signed range check.
   function automatic exp_t refModel(input logic [31:0] a, input logic [31:0] b,
                                     input logic cin, input logic sub, input int w);
      longint mask, ua, ub, sa, sb, full, total, lim, c;
      exp_t   e;
      mask = (longint'(1) << w) - 1;
      lim  = longint'(1) << (w - 1);
      ua   = longint'(a) & mask;
      ub   = longint'(b) & mask;
      sa   = (ua >= lim) ? ua - (longint'(1) << w) : ua;
      sb   = (ub >= lim) ? ub - (longint'(1) << w) : ub;
      c    = cin ? 1 : 0;
      if (sub) begin
         full  = ua - ub;
         e.co  = (ua >= ub);
         total = sa - sb;
      end else begin
         full  = ua + ub + c;
         e.co  = ((full >> w) & 1) != 0;
         total = sa + sb + c;
      end
      e.s  = 32'(full & mask);
      e.ov = (total >= lim) || (total < -lim);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic reportFail(input string name);
      nChecks++;
      nErrors++;
      $display("[TB] FAIL %s at %0t", name, $time);
   endtask

   // Per-instance monitor: compare on consume, flag any valid with nothing expected, record accepts.
   always @(negedge clk) begin : mon16
      exp_t e;
      if (rst_n) begin
         if (bus16.out_valid) begin
            if (q16.size() == 0) reportFail("w16 unexpected result with empty scoreboard");
            else if (bus16.out_ready) begin
               e = q16.pop_front();
               checkOutput("w16 result {sum,cout,ovf}", 64'({bus16.sum, bus16.cout, bus16.ovf}),
                           64'({e.s[15:0], e.co, e.ov}));
            end
         end
         if (bus16.in_valid && bus16.in_ready)
            q16.push_back(refModel(32'(bus16.a), 32'(bus16.b), bus16.cin, bus16.sub, 16));
      end
   end

   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst_n) begin
         if (bus8.out_valid) begin
            if (q8.size() == 0) reportFail("w8 unexpected result with empty scoreboard");
            else if (bus8.out_ready) begin
               e = q8.pop_front();
               checkOutput("w8 result {sum,cout,ovf}", 64'({bus8.sum, bus8.cout, bus8.ovf}),
                           64'({e.s[7:0], e.co, e.ov}));
            end
         end
         if (bus8.in_valid && bus8.in_ready)
            q8.push_back(refModel(32'(bus8.a), 32'(bus8.b), bus8.cin, bus8.sub, 8));
      end
   end

   always @(negedge clk) begin : mon32
      exp_t e;
      if (rst_n) begin
         if (bus32.out_valid) begin
            if (q32.size() == 0) reportFail("w32 unexpected result with empty scoreboard");
            else if (bus32.out_ready) begin
               e = q32.pop_front();
               checkOutput("w32 result {sum,cout,ovf}", 64'({bus32.sum, bus32.cout, bus32.ovf}),
                           64'({e.s, e.co, e.ov}));
            end
         end
         if (bus32.in_valid && bus32.in_ready)
            q32.push_back(refModel(bus32.a, bus32.b, bus32.cin, bus32.sub, 32));
      end
   end

   // Drives one beat on the 16-bit port and returns just after the edge that accepted it.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      bit accepted;
      accepted       = 1'b0;
      bus16.a        = a;
      bus16.b        = b;
      bus16.cin      = cin;
      bus16.sub      = sub;
      bus16.in_valid = 1'b1;
      for (int i = 0; i < 200 && !accepted; i++) begin
         @(negedge clk);
         accepted = bus16.in_ready;
         @(posedge clk);
         #1;
      end
      if (!accepted) reportFail("w16 beat never accepted (in_ready timeout)");
   endtask

   // Single beat into an empty pipe: out_valid must rise exactly 4 edges after the accept edge.
   task automatic singleBeat(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
      applyStimulus(a, b, cin, sub);
      bus16.in_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         checkOutput("w16 out_valid before latency", 64'(bus16.out_valid), 64'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("w16 out_valid at latency", 64'(bus16.out_valid), 64'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain16();
      for (int i = 0; i < 50 && q16.size() != 0; i++) @(posedge clk);
      #1;
      checkOutput("w16 scoreboard drained", 64'(q16.size()), 64'd0);
      checkOutput("w16 trailing bubble clears out_valid", 64'(bus16.out_valid), 64'd0);
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] aborted");
   end

   initial begin : main
      logic [15:0] holdA, holdB;
      logic        holdCin, holdSub;
      logic [31:0] tblA [5];
      logic [31:0] tblB [5];
      logic        tblSub [5];

      bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
      bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b1;
      bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;

      #12;
      checkOutput("reset out_valid", 64'(bus16.out_valid), 64'd0);
      checkOutput("reset sum",       64'(bus16.sum),       64'd0);
      checkOutput("reset cout",      64'(bus16.cout),      64'd0);
      checkOutput("reset ovf",       64'(bus16.ovf),       64'd0);
      checkOutput("reset in_ready",  64'(bus16.in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] directed single beats");
      singleBeat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      singleBeat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      singleBeat(16'h1234, 16'h4321, 1'b1, 1'b0);
      singleBeat(16'h0005, 16'h0007, 1'b1, 1'b1);
      singleBeat(16'h8000, 16'h0001, 1'b0, 1'b1);

      $display("[TB] carries across group boundaries");
      applyStimulus(16'h000F, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h0FFF, 16'h0001, 1'b0, 1'b0);
      applyStimulus(16'h0100, 16'h0001, 1'b0, 1'b1);
      applyStimulus(16'h1000, 16'h0001, 1'b1, 1'b1);
      bus16.in_valid = 1'b0;
      drain16();

      $display("[TB] random stream with bubbles");
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            bus16.in_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      bus16.in_valid = 1'b0;
      drain16();

      $display("[TB] back-pressure with full pipeline");
      bus16.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      holdA = 16'($urandom); holdB = 16'($urandom); holdCin = 1'($urandom); holdSub = 1'($urandom);
      bus16.a = holdA; bus16.b = holdB; bus16.cin = holdCin; bus16.sub = holdSub;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("stall in_ready", 64'(bus16.in_ready), 64'd0);
         checkOutput("stall out_valid", 64'(bus16.out_valid), 64'd1);
         checkOutput("stall held result", 64'({bus16.sum, bus16.cout, bus16.ovf}),
                     64'({q16[0].s[15:0], q16[0].co, q16[0].ov}));
         @(posedge clk);
         #1;
      end
      checkOutput("stall beats in flight", 64'(q16.size()), 64'd4);
      bus16.out_ready = 1'b1;
      applyStimulus(holdA, holdB, holdCin, holdSub);
      bus16.in_valid = 1'b0;
      drain16();

      $display("[TB] reset with beats in flight");
      for (int i = 0; i < 3; i++) applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      bus16.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      q16.delete();
      q8.delete();
      q32.delete();
      #1;
      checkOutput("async reset out_valid", 64'(bus16.out_valid), 64'd0);
      checkOutput("async reset sum",       64'(bus16.sum),       64'd0);
      checkOutput("async reset cout",      64'(bus16.cout),      64'd0);
      checkOutput("async reset ovf",       64'(bus16.ovf),       64'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      singleBeat(16'h0001, 16'h0001, 1'b0, 1'b0);
      drain16();

      $display("[TB] parameter sweep 8/4 and 32/8");
      tblA[0] = 32'h000000FF; tblB[0] = 32'h00000001; tblSub[0] = 1'b0;
      tblA[1] = 32'h0000FFFF; tblB[1] = 32'h00000001; tblSub[1] = 1'b0;
      tblA[2] = 32'h00FFFFFF; tblB[2] = 32'h00000001; tblSub[2] = 1'b0;
      tblA[3] = 32'h7FFFFFFF; tblB[3] = 32'h00000001; tblSub[3] = 1'b0;
      tblA[4] = 32'h80000000; tblB[4] = 32'h00000001; tblSub[4] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
         bus32.a = tblA[i]; bus32.b = tblB[i]; bus32.cin = 1'b0; bus32.sub = tblSub[i];
         bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
         bus8.a = tblA[i][7:0]; bus8.b = tblB[i][7:0]; bus8.cin = 1'b0; bus8.sub = tblSub[i];
         @(posedge clk);
         #1;
      end
      for (int cyc = 0; cyc < 80; cyc++) begin
         bus8.in_valid   = ($urandom_range(0, 3) != 0);
         bus8.out_ready  = ($urandom_range(0, 3) != 0);
         bus8.a          = 8'($urandom);
         bus8.b          = 8'($urandom);
         bus8.cin        = 1'($urandom);
         bus8.sub        = 1'($urandom);
         bus32.in_valid  = ($urandom_range(0, 3) != 0);
         bus32.out_ready = ($urandom_range(0, 3) != 0);
         bus32.a         = $urandom;
         bus32.b         = $urandom;
         bus32.cin       = 1'($urandom);
         bus32.sub       = 1'($urandom);
         @(posedge clk);
         #1;
      end
      bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b1;
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("w8 scoreboard drained",  64'(q8.size()),        64'd0);
      checkOutput("w32 scoreboard drained", 64'(q32.size()),       64'd0);
      checkOutput("w8 idle out_valid",      64'(bus8.out_valid),   64'd0);
      checkOutput("w32 idle out_valid",     64'(bus32.out_valid),  64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
      $finish;
   end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor. Operands are split into GROUP-bit lookahead groups. Each group is resolved in its own pipeline stage, with the group carry registered between stages, giving one result per clock at WIDTH/GROUP cycles of latency. It sits behind valid/ready streaming interfaces on both sides, so datapath blocks can drop it in wherever a wide add/sub must close timing at full clock rate.

## Interface
- WIDTH, 16, operand and result width in bits; must be a multiple of GROUP, and at least GROUP.
- GROUP, 4, lookahead group width; one group is resolved per stage. STAGES = WIDTH/GROUP.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used in add mode only.
- sub  input  1  0 = A+B+cin; 1 = A−B.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. In sub mode, 1 means no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- **Accept:** an input beat is accepted on a rising edge where in_valid && in_ready.
- **Sub mode:** B is inverted and the effective carry-in is forced to 1; cin is ignored. The mode is captured with the beat.
- **Stage k (k = 0..STAGES−1):**
  - Compute G = a_k & b_k and P = a_k ^ b_k over group k.
  - Compute the full lookahead carries inside the group from the incoming carry, with no ripple between bits.
  - Sum bits for the group are P ^ C.
  - The group carry-out is registered with the beat.
- **Operand skew:** operand bits for groups above k travel with the beat unmodified. Sum bits for groups below k are held in the stage register.
- **Final stage register:** this is the output register; it drives sum, cout, ovf and out_valid.
- **ovf:** computed in the last stage from the carry into bit WIDTH−1 and the carry out of bit WIDTH−1.
- **Flow control:** single global advance signal, advance = !out_valid || out_ready.
  - in_ready = advance.
  - On advance, every stage loads from the stage below; stage 0 loads the input, and its valid bit = in_valid.
  - Invalid slots (bubbles) advance like data, and a trailing bubble clears out_valid.
  - When advance is 0, every stage register holds, and sum/cout/ovf/out_valid stay stable.
- **Reset:**
  - All stage valid bits and data registers clear to 0 immediately on rst_n low, independent of clk.
  - Outputs after reset: out_valid=0, sum=0, cout=0, ovf=0. in_ready=1, because out_valid=0.
  - Beats in flight at reset are discarded; no partial result is ever presented.

## Timing
- **Latency:** STAGES rising edges from the accept edge to out_valid. The accept edge counts as edge 1. With WIDTH=16, GROUP=4: accept at edge n, result visible after edge n+3.
- **Throughput:** one beat per cycle while out_ready stays high.
- **in_ready:** combinational from out_valid and out_ready; no other combinational input-to-output paths.
- **Simultaneous events:**
  - Input accept and output consume on the same edge are both legal: the result leaves and the new beat enters stage 0.
  - When out_ready deasserts with the pipeline full, no beat is lost or duplicated.
- **Ordering:** results emerge in acceptance order.
- **Combinational depth:** one GROUP-bit lookahead block per stage, independent of WIDTH.

## Test plan
Defaults WIDTH=16, GROUP=4.
- **Single beats:**
  - Add 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0, out_valid 4 edges after accept.
  - Add 0x7FFF+0x0001 → 0x8000, cout=0, ovf=1.
  - Add 0x1234+0x4321, cin=1 → 0x5556, cout=0, ovf=0.
- **Subtract:**
  - 0x0005−0x0007, cin=1 → 0xFFFE, cout=0, ovf=0; cin is ignored.
  - 0x8000−0x0001 → 0x7FFF, cout=1, ovf=1.
- **Back-to-back stream:** 20 random beats, out_ready=1, in_valid toggled to insert bubbles → results in order, matching a reference model, one per cycle where inputs were contiguous.
- **Back-pressure:** fill the pipeline, hold out_ready=0 for 5 cycles → in_ready=0, outputs stable throughout; release → all 4 results delivered in order, no loss or duplicate.
- **Reset mid-operation:** assert rst_n=0 between edges with 3 beats in flight → out_valid and sum/cout/ovf go to 0 immediately. After release, no stale result ever appears. The next beat, 0x0001+0x0001, yields 0x0002 after 4 edges.
- **Parameter sweep:**
  - Repeat random add/sub checks with WIDTH=8, GROUP=4 (latency 2) and WIDTH=32, GROUP=8 (latency 4).
  - Check the carry across every group boundary, e.g. 0x00FF+0x0001 → 0x0100 at WIDTH=16.
